// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with a valid/ready handshake, a flush control and an
// optional 2-entry skid buffer. Empty or flushed slots present zero WB/M control
// bits so a bubble can never write memory or the register file.
module exmem_pipe_reg #(
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int SKID   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB,
    input  logic [M_W-1:0]    M,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteDataIn,
    input  logic [REG_W-1:0]  RegRD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   WBreg,
    output logic [M_W-1:0]    Mreg,
    output logic [DATA_W-1:0] ALUreg,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic [REG_W-1:0]  RegRDreg,
    output logic [1:0]        occupancy
);

    localparam bit HAS_SKID = (SKID != 0);

    logic              main_valid;
    logic              skid_valid;
    logic [WB_W-1:0]   skid_wb;
    logic [M_W-1:0]    skid_m;
    logic [DATA_W-1:0] skid_alu;
    logic [DATA_W-1:0] skid_wd;
    logic [REG_W-1:0]  skid_rd;
    logic              accept;
    logic              drain;

    // Ready: registered-only with the skid slot, pass-through of out_ready without it.
    always_comb begin
        if (HAS_SKID) begin
            in_ready = ~skid_valid & ~reset;
        end else begin
            in_ready = (~main_valid | out_ready) & ~reset;
        end
    end

    assign accept    = in_valid & in_ready;
    assign drain     = main_valid & out_ready;
    assign out_valid = main_valid;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Main slot: refill from skid first, otherwise from EX; clear control when emptied.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid   <= 1'b0;
            WBreg        <= '0;
            Mreg         <= '0;
            ALUreg       <= '0;
            WriteDataOut <= '0;
            RegRDreg     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            WBreg      <= '0;
            Mreg       <= '0;
        end else if (skid_valid && drain) begin
            main_valid   <= 1'b1;
            WBreg        <= skid_wb;
            Mreg         <= skid_m;
            ALUreg       <= skid_alu;
            WriteDataOut <= skid_wd;
            RegRDreg     <= skid_rd;
        end else if (accept && (!main_valid || drain)) begin
            main_valid   <= 1'b1;
            WBreg        <= WB;
            Mreg         <= M;
            ALUreg       <= ALUOut;
            WriteDataOut <= WriteDataIn;
            RegRDreg     <= RegRD;
        end else if (drain) begin
            main_valid <= 1'b0;
            WBreg      <= '0;
            Mreg       <= '0;
        end
    end

    // Skid slot: catches an accept while main is stalled; never loaded when SKID=0.
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_wb    <= '0;
            skid_m     <= '0;
            skid_alu   <= '0;
            skid_wd    <= '0;
            skid_rd    <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (skid_valid && drain) begin
            skid_valid <= 1'b0;
        end else if (HAS_SKID && accept && main_valid && !drain) begin
            skid_valid <= 1'b1;
            skid_wb    <= WB;
            skid_m     <= M;
            skid_alu   <= ALUOut;
            skid_wd    <= WriteDataIn;
            skid_rd    <= RegRD;
        end
    end

endmodule

// File: doc/exmem_pipe_reg.md
Name: exmem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register, the successor to the fixed-width free-running EX/MEM latch. It adds a valid/ready handshake, a flush control and an optional 2-entry skid buffer, so the MEM stage can stall without a combinational ready path back into EX. Empty or flushed slots always present zeroed WB/M control bits, so a bubble never writes memory or the register file.

Parameters:
WB_W, 2, width of write-back control field
M_W, 3, width of memory control field
DATA_W, 32, width of ALU result and store data
REG_W, 5, width of destination register index
SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single slot (in_ready combinational from out_ready)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  discard all held and incoming entries this cycle
in_valid  in  1  EX presents a valid entry
in_ready  out  1  register can accept this cycle
WB  in  WB_W  write-back control from EX
M  in  M_W  memory control from EX
ALUOut  in  DATA_W  ALU result
WriteDataIn  in  DATA_W  store data
RegRD  in  REG_W  destination register
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM consumes the entry this cycle
WBreg  out  WB_W  registered WB
Mreg  out  M_W  registered M
ALUreg  out  DATA_W  registered ALU result
WriteDataOut  out  DATA_W  registered store data
RegRDreg  out  REG_W  registered destination register
occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Event definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Storage: main slot drives the outputs; skid slot is internal and exists only when SKID=1. Each slot has a valid bit.
- Reset (priority over everything): both valid bits 0 and all outputs 0, including data fields. in_ready = 0 while reset is high; it is 1 on the first cycle after reset.
- Flush (priority below reset, above all transfers): both valid bits cleared and WBreg/Mreg set to 0 on the next edge. Data outputs hold. A concurrent accept is discarded, and a concurrent drain still counts as consumed by MEM.
- Latency: an accepted entry appears on the outputs the cycle after acceptance when the main slot is free or draining.
- SKID=1:
  - in_ready = ~skid_valid & ~reset, from registers only.
  - Main empty, accept: load main.
  - Main full, drain, accept: load main.
  - Main full, no drain, accept: load skid; in_ready goes low next cycle.
  - Skid full, drain: main <= skid, skid cleared.
  - Main full, drain, no accept, skid empty: main becomes empty.
- SKID=0:
  - in_ready = (~out_valid | out_ready) & ~reset.
  - Single slot, same load/empty rules as above; no skid slot.
- Main becomes empty: WBreg and Mreg are cleared to 0 on that edge. ALUreg, WriteDataOut and RegRDreg hold their last values.
- Stall: out_valid=1 and out_ready=0 means all outputs hold and are stable.
- Throughput is 1 entry per cycle under continuous in_valid and out_ready in both modes; no bubbles are inserted.
- occupancy = main_valid + skid_valid.
- Assertions: no entry is lost or duplicated; order is strictly FIFO.

Test Plan:
- Reset, then in_valid=1 with ALUOut=0x0000_0010, RegRD=5, WB=2'b11, M=3'b010, out_ready=1 -> next cycle out_valid=1, ALUreg=0x10, RegRDreg=5, WBreg=3, Mreg=2. Streaming 8 entries gives 8 consecutive valid outputs in order.
- SKID=1, out_ready=0, send A=0x1 then B=0x2 -> out_valid=1, ALUreg=0x1, occupancy=2, in_ready=0. Then out_ready=1 for 2 cycles -> outputs 0x1 then 0x2, then occupancy=0, WBreg=0, Mreg=0.
- Flush while occupancy=2 with in_valid=1 (C=0x3) -> next cycle out_valid=0, occupancy=0, WBreg=0, Mreg=0, and C never appears on the outputs.
- Reset asserted with occupancy=1 and in_valid=1 -> in_ready=0 during reset; all outputs 0 next cycle; the held entry is lost.
- SKID=0, out_valid=1, out_ready toggling 1,0,1 with in_valid=1 -> in_ready follows out_ready combinationally, every entry is delivered exactly once, occupancy never exceeds 1.
- Random in_valid/out_ready/flush for 10k cycles against a queue scoreboard -> output sequence equals the accepted sequence minus flushed entries; control fields are zero whenever out_valid=0.
